// File: rtl/riscky_pkg.sv
// Shared encodings for the riscky pipeline: branch funct3 values, writeback selects
// and the default datapath width.
package riscky_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    RS_ALU = 2'b00,
    RS_MEM = 2'b01,
    RS_PC4 = 2'b10,
    RS_IMM = 2'b11
  } result_src_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode from funct3 and the flags of the A-B subtraction.
module branch_cond
  import riscky_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       v_i,
  input  logic       c_i,
  input  logic       z_i,
  input  logic       n_i,
  output logic       cond_o
);

  // C is the no-borrow carry, so unsigned less-than is ~C.
  always_comb begin
    cond_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond_o = z_i;
      F3_BNE:  cond_o = ~z_i;
      F3_BLT:  cond_o = n_i ^ v_i;
      F3_BGE:  cond_o = ~(n_i ^ v_i);
      F3_BLTU: cond_o = ~c_i;
      F3_BGEU: cond_o = c_i;
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: branch resolution, PC redirect, wrong-path squash, EX/MEM register
// under valid/ready, and saturating branch statistics.
module ex_mem_stage
  import riscky_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int KILL_SLOTS = 2,
  parameter int CNT_W      = 16,
  localparam int SQ_W      = $clog2(KILL_SLOTS + 2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_v,
  input  logic            alu_c,
  input  logic            alu_z,
  input  logic            alu_n,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      funct3,
  input  logic            branch,
  input  logic            jump,
  input  logic            jump_reg,
  input  logic            reg_write,
  input  logic            mem_write,
  input  logic [1:0]      result_src,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  input  logic            cnt_clr,
  output logic            pc_src,
  output logic [XLEN-1:0] pc_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_alu_result,
  output logic [XLEN-1:0] out_write_data,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [4:0]      out_rd,
  output logic [1:0]      out_result_src,
  output logic            out_reg_write,
  output logic            out_mem_write,
  output logic            out_misalign,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [SQ_W-1:0] squash_cnt
);

  // Handshake: fire = in_valid & in_ready & ~flush; in_ready = ~out_valid | out_ready.
  // A held bundle stays put while out_valid & ~out_ready.

  logic            cond;
  logic            fire, live, taken, misalign;
  logic [SQ_W-1:0] squash_q, squash_d;
  logic            valid_q;
  logic [CNT_W-1:0] branch_q, taken_q;

  branch_cond u_cond (
    .funct3_i (funct3),
    .v_i      (alu_v),
    .c_i      (alu_c),
    .z_i      (alu_z),
    .n_i      (alu_n),
    .cond_o   (cond)
  );

  assign in_ready  = ~valid_q | out_ready;
  assign fire      = in_valid & in_ready & ~flush;
  assign live      = fire & (squash_q == '0);
  assign taken     = live & (jump | (branch & cond));
  assign pc_target = jump_reg ? {alu_result[XLEN-1:1], 1'b0} : pc + imm;
  assign misalign  = taken & (pc_target[1:0] != 2'b00);
  assign pc_src    = taken & ~misalign & ~rst;

  always_comb begin
    squash_d = squash_q;
    if (flush)
      squash_d = '0;
    else if (pc_src)
      squash_d = SQ_W'(KILL_SLOTS);
    else if (fire && squash_q != '0)
      squash_d = squash_q - SQ_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      squash_q       <= '0;
      valid_q        <= 1'b0;
      out_alu_result <= '0;
      out_write_data <= '0;
      out_pc_plus4   <= '0;
      out_rd         <= '0;
      out_result_src <= '0;
      out_reg_write  <= 1'b0;
      out_mem_write  <= 1'b0;
      out_misalign   <= 1'b0;
    end else begin
      squash_q <= squash_d;
      if (fire) begin
        valid_q <= live;
        if (live) begin
          out_alu_result <= alu_result;
          out_write_data <= rs2_data;
          out_pc_plus4   <= pc + XLEN'(4);
          out_rd         <= rd_addr;
          out_result_src <= result_src;
          out_reg_write  <= reg_write;
          out_mem_write  <= mem_write;
          out_misalign   <= misalign;
        end
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Only redirecting branches count as taken; a misaligned target counts as a branch only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_q <= '0;
      taken_q  <= '0;
    end else if (cnt_clr) begin
      branch_q <= '0;
      taken_q  <= '0;
    end else if (live && branch) begin
      if (branch_q != '1) branch_q <= branch_q + CNT_W'(1);
      if (pc_src && taken_q != '1) taken_q <= taken_q + CNT_W'(1);
    end
  end

  assign out_valid  = valid_q;
  assign branch_cnt = branch_q;
  assign taken_cnt  = taken_q;
  assign squash_cnt = squash_q;

endmodule
